irq_pending_latch: RTL and testbench
====================================

# irq_pending_latch

Request-capture stage directly upstream of the 4-to-2 priority encoder. Turns four asynchronous, edge-signalled request lines into sticky pending bits and applies a programmable mask. Drives the encoder's 4-bit input `I`, and takes back the encoder's 2-bit result as the acknowledge index to clear the serviced request. Also flags lost (overrun) requests per line.

## Interface
- `MASK_RST`, default 4'b0000: reset value of the mask register; bit = 1 masks that line.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `req`  in  4  raw request lines; a rising edge requests service.
- `mask_we`  in  1  loads `mask_d` into the mask register on this edge.
- `mask_d`  in  4  new mask value.
- `ack`  in  1  single-cycle acknowledge; clears `pending[ack_idx]`.
- `ack_idx`  in  2  index of the serviced line (wired from encoder `Y`).
- `ovf_clr`  in  1  clears all overrun flags.
- `I`  out  4  `pending & ~mask`; feeds the encoder input.
- `irq`  out  1  `|I`.
- `pending`  out  4  raw pending register, unmasked.
- `ovf`  out  4  sticky overrun flags.

## Operation
- Input path: `req` passes through a 2-flop synchronizer (`s1`, `s2`), then a delay flop `d`.
- Edge detection: `edge[i] = s2[i] & ~d[i]`.
- Pending set/clear, evaluated per bit on each edge:
  - `edge[i]` sets `pending[i]`.
  - `ack && ack_idx==i` clears `pending[i]`.
  - If an edge and an ack hit the same bit in the same cycle, set wins and the bit stays 1.
- Overrun: `ovf[i]` sets when `edge[i]` arrives while `pending[i]` is already 1 and that bit is not being acked in the same cycle.
  - `ovf_clr` clears all four flags.
  - A set on the same cycle as `ovf_clr` wins.
- Masking:
  - Mask affects only `I` and `irq`.
  - Masked lines still latch into `pending` and still raise `ovf`.
  - Unmasking a pending line exposes it on the next cycle.
- Ack rules:
  - `ack` while `irq==0`, or to a bit that is not pending, has no effect.
  - `ack_idx` of a masked pending bit clears it anyway.
- Outputs `I` and `irq` are combinational from the `pending` and `mask` registers only; there is no combinational path from `req`, `ack`, or `mask_d` to any output.

## Timing
- Reset (async assert, released on a clock edge):
  - `s1`, `s2`, `d`, `pending`, `ovf` all go to 0, so `I=0`, `irq=0`.
  - `mask` goes to `MASK_RST`.
  - A `req` held high through reset release is seen as a rising edge after release.
- Latency, with `req` rising before edge k:
  - `s1=1` after k, `s2=1` after k+1.
  - `pending` and `I` are set after k+2 (3 rising edges).
- Minimum `req` pulse width: 2 clock periods (must be sampled by `s1`).
- `ack` at edge k clears `pending` and `I` after edge k; the encoder output updates combinationally in the same cycle.
- `mask_we` at edge k takes effect on `I` after k.
- Reset asserted mid-operation discards all pending bits, overrun flags, and in-flight synchronizer state immediately, with no clock needed.
- Throughput: one ack per cycle, back-to-back acks are allowed.

## Configuration
- `IRQ_SYNC_EN` defined:
  - 2-flop synchronizer present, as above.
  - `req` may be fully asynchronous.
  - Set latency 3 edges.
- `IRQ_SYNC_EN` undefined:
  - `s1`/`s2` removed; `edge = req & ~d`, with `d` sampling `req` directly.
  - `req` must be synchronous to `clk`.
  - `pending` sets after the first edge where `req` is seen high.
  - Minimum pulse width 1 clock.
  - All other behaviour is identical.

## Test plan
- Reset: assert `rst` asynchronously mid-cycle with `pending=4'b1010` -> `pending=0`, `ovf=0`, `irq=0` immediately; `mask=MASK_RST` (4'b0000).
- Latency: `req` goes 0000 -> 0100 held 2 cycles (sync on) -> `I=4'b0100`, `irq=1` exactly after the 3rd edge. Encoder yields `Y=2`; `ack=1`, `ack_idx=2` for one cycle -> `I=0000` next cycle.
- Priority chain: `req` pulses 1011 -> `I=1011`. Ack each index returned by the encoder (3, 1, 0) on consecutive cycles -> `I` goes 0011, then 0001, then 0000.
- Mask: `mask_we=1`, `mask_d=1000`, then `req` pulse 1000 -> `pending=1000`, `I=0000`, `irq=0`. Write `mask_d=0000` -> `I=1000` the next cycle.
- Overrun and collisions:
  - Second `req[1]` pulse while `pending[1]=1` -> `ovf=0010`.
  - Edge on bit 1 coincident with `ack_idx=1` -> `pending[1]` stays 1, `ovf` unchanged.
  - `ovf_clr` -> `ovf=0000`.
- Sync off (`IRQ_SYNC_EN` undefined): single-cycle synchronous `req=0001` pulse -> `pending=0001` after 1 edge.

Source files
------------

// File: rtl/irq_pending_latch.sv
// irq_pending_latch
//   Request-capture stage feeding a 4-to-2 priority encoder. Each of the four
//   request lines is edge-detected, latched into a sticky pending bit and
//   masked onto the encoder input. The encoder result comes back as the
//   acknowledge index and clears the serviced bit. Overruns (an edge on a line
//   that is still pending) are flagged per line.
//
//   Build option: define IRQ_SYNC_EN to insert a 2-flop synchronizer on req
//   (fully asynchronous req, 3-edge set latency). Without it, req must be
//   synchronous to clk and pending sets on the first edge req is seen high.
//
//   Ports:
//     clk      in   rising-edge clock
//     rst      in   asynchronous active-high reset
//     req      in   [3:0] request lines, rising edge requests service
//     mask_we  in   load mask_d into the mask register
//     mask_d   in   [3:0] new mask value (1 = line masked)
//     ack      in   single-cycle acknowledge
//     ack_idx  in   [1:0] index of the serviced line (encoder Y)
//     ovf_clr  in   clear all overrun flags
//     I        out  [3:0] pending & ~mask, encoder input
//     irq      out  |I
//     pending  out  [3:0] raw pending register
//     ovf      out  [3:0] sticky overrun flags
module irq_pending_latch #(
  parameter logic [3:0] MASK_RST = 4'b0000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       mask_we,
  input  logic [3:0] mask_d,
  input  logic       ack,
  input  logic [1:0] ack_idx,
  input  logic       ovf_clr,
  output logic [3:0] I,
  output logic       irq,
  output logic [3:0] pending,
  output logic [3:0] ovf
);

  logic [3:0] d_q;
  logic [3:0] d_d;
  logic [3:0] pending_q;
  logic [3:0] pending_d;
  logic [3:0] ovf_q;
  logic [3:0] ovf_d;
  logic [3:0] mask_reg_q;
  logic [3:0] mask_reg_d;
  logic [3:0] seen_s;
  logic [3:0] req_edge_s;
  logic [3:0] ack_dec_s;
  logic [3:0] clr_s;
  logic       irq_s;

`ifdef IRQ_SYNC_EN
  logic [3:0] s1_q;
  logic [3:0] s1_d;
  logic [3:0] s2_q;
  logic [3:0] s2_d;

  // Synchronizer next-state: req -> s1 -> s2.
  always_comb begin
    s1_d = req;
    s2_d = s1_q;
  end

  // Synchronizer flops, cleared by reset so in-flight requests are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= 4'b0000;
      s2_q <= 4'b0000;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign seen_s = s2_q;
`else
  assign seen_s = req;
`endif

  // Acknowledge index decode to a one-hot clear vector.
  always_comb begin
    ack_dec_s = 4'b0000;
    case (ack_idx)
      2'd0:    ack_dec_s = 4'b0001;
      2'd1:    ack_dec_s = 4'b0010;
      2'd2:    ack_dec_s = 4'b0100;
      2'd3:    ack_dec_s = 4'b1000;
      default: ack_dec_s = 4'b0000;
    endcase
  end

  assign irq_s = |(pending_q & ~mask_reg_q);

  // Next-state for edge delay, pending, overrun and mask registers.
  always_comb begin
    d_d        = seen_s;
    req_edge_s = seen_s & ~d_q;
    // An ack only counts while irq is raised; it may then clear a masked bit.
    if (ack && irq_s) begin
      clr_s = ack_dec_s;
    end else begin
      clr_s = 4'b0000;
    end
    // Set wins over a coincident clear.
    pending_d = (pending_q & ~clr_s) | req_edge_s;
    // A new edge on a still-pending, un-acked line is an overrun; set beats clear.
    if (ovf_clr) begin
      ovf_d = req_edge_s & pending_q & ~clr_s;
    end else begin
      ovf_d = ovf_q | (req_edge_s & pending_q & ~clr_s);
    end
    if (mask_we) begin
      mask_reg_d = mask_d;
    end else begin
      mask_reg_d = mask_reg_q;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_q        <= 4'b0000;
      pending_q  <= 4'b0000;
      ovf_q      <= 4'b0000;
      mask_reg_q <= MASK_RST;
    end else begin
      d_q        <= d_d;
      pending_q  <= pending_d;
      ovf_q      <= ovf_d;
      mask_reg_q <= mask_reg_d;
    end
  end

  // Outputs depend on registers only.
  assign I       = pending_q & ~mask_reg_q;
  assign irq     = irq_s;
  assign pending = pending_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_irq_pending_latch.sv
// Randomized + directed self-checking bench for irq_pending_latch.
// The reference model tracks the sampled req history, pending/ovf/mask sets
// and the priority encoder as plain bit arithmetic.
module tb_irq_pending_latch;

`ifdef IRQ_SYNC_EN
  localparam int LAG = 2;
  localparam int LAT = 3;
`else
  localparam int LAG = 0;
  localparam int LAT = 1;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       mask_we;
  logic [3:0] mask_d;
  logic       ack;
  logic [1:0] ack_idx;
  logic       ovf_clr;
  logic [3:0] I;
  logic       irq;
  logic [3:0] pending;
  logic [3:0] ovf;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  logic [3:0] m_pend;
  logic [3:0] m_ovf;
  logic [3:0] m_mask;
  logic [3:0] hist [0:3];

  irq_pending_latch #(.MASK_RST(4'b0000)) dut (
    .clk(clk), .rst(rst), .req(req), .mask_we(mask_we), .mask_d(mask_d),
    .ack(ack), .ack_idx(ack_idx), .ovf_clr(ovf_clr),
    .I(I), .irq(irq), .pending(pending), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  // highest-index set bit wins, as the downstream encoder does
  function automatic logic [1:0] enc(input logic [3:0] v);
    for (int i = 3; i >= 0; i--) begin
      if (v[i]) return 2'(i);
    end
    return 2'd0;
  endfunction

  task automatic model_reset();
    m_pend = 4'b0000;
    m_ovf  = 4'b0000;
    m_mask = 4'b0000;
    for (int i = 0; i < 4; i++) hist[i] = 4'b0000;
  endtask

  // one clock edge of the reference model, using the inputs applied this cycle
  task automatic model_step();
    logic [3:0] e;
    logic [3:0] clr;
    for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = req;
    e   = hist[LAG] & ~hist[LAG+1];
    clr = 4'b0000;
    if (ack && ((m_pend & ~m_mask) != 4'b0000)) clr[ack_idx] = 1'b1;
    m_ovf  = (ovf_clr ? 4'b0000 : m_ovf) | (e & m_pend & ~clr);
    m_pend = (m_pend & ~clr) | e;
    if (mask_we) m_mask = mask_d;
  endtask

  task automatic cmp_all(input string tag);
    check_eq({tag, ".pending"}, pending, m_pend);
    check_eq({tag, ".ovf"}, ovf, m_ovf);
    check_eq({tag, ".I"}, I, m_pend & ~m_mask);
    check_eq({tag, ".irq"}, {3'b000, irq}, {3'b000, |(m_pend & ~m_mask)});
  endtask

  // advance one edge; return at the following falling edge with outputs checked
  task automatic tick(input string tag);
    @(posedge clk);
    model_step();
    @(negedge clk);
    cmp_all(tag);
  endtask

  task automatic idle_inputs();
    mask_we = 1'b0; mask_d = 4'b0000; ack = 1'b0; ack_idx = 2'd0; ovf_clr = 1'b0;
  endtask

  // two-cycle pulse, then enough idle cycles for it to land in pending
  task automatic pulse(input logic [3:0] v, input string tag);
    req = v;
    tick(tag);
    tick(tag);
    req = 4'b0000;
    for (int i = 0; i < LAT; i++) tick(tag);
  endtask

  initial begin
    rst = 1'b1;
    req = 4'b0000;
    idle_inputs();
    model_reset();
    repeat (2) @(negedge clk);
    cmp_all("reset");
    rst = 1'b0;

    // latency of a single request, then ack via encoder result
    req = 4'b0100;
    for (int i = 1; i <= 3; i++) begin
      tick("lat");
      if (i == 2) req = 4'b0000;
      if (i == LAT - 1) check_eq("lat_early", I, 4'b0000);
    end
    check_eq("lat_I", I, 4'b0100);
    check_eq("lat_irq", {3'b000, irq}, 4'b0001);
    ack = 1'b1; ack_idx = enc(m_pend & ~m_mask);
    tick("lat_ack");
    ack = 1'b0;
    check_eq("lat_ack_I", I, 4'b0000);

    // priority chain 1011 serviced 3, 1, 0
    pulse(4'b1011, "prio");
    check_eq("prio_I", I, 4'b1011);
    ack = 1'b1;
    ack_idx = enc(m_pend & ~m_mask); tick("prio_a3"); check_eq("prio_a3_I", I, 4'b0011);
    ack_idx = enc(m_pend & ~m_mask); tick("prio_a1"); check_eq("prio_a1_I", I, 4'b0001);
    ack_idx = enc(m_pend & ~m_mask); tick("prio_a0"); check_eq("prio_a0_I", I, 4'b0000);
    ack = 1'b0;

    // masking: line latches but stays hidden; ack with irq low is ignored
    mask_we = 1'b1; mask_d = 4'b1000; tick("mask_wr"); idle_inputs();
    pulse(4'b1000, "mask");
    check_eq("mask_pend", pending, 4'b1000);
    check_eq("mask_I", I, 4'b0000);
    check_eq("mask_irq", {3'b000, irq}, 4'b0000);
    ack = 1'b1; ack_idx = 2'd3; tick("ack_noirq"); ack = 1'b0;
    check_eq("ack_noirq_pend", pending, 4'b1000);
    mask_we = 1'b1; mask_d = 4'b0000; tick("unmask"); idle_inputs();
    check_eq("unmask_I", I, 4'b1000);
    ack = 1'b1; ack_idx = 2'd3; tick("ack3"); ack = 1'b0;

    // overrun, clear, then edge colliding with ack on the same bit
    pulse(4'b0010, "ovf1");
    pulse(4'b0010, "ovf2");
    check_eq("ovf_set", ovf, 4'b0010);
    ovf_clr = 1'b1; tick("ovf_clr"); ovf_clr = 1'b0;
    check_eq("ovf_clr", ovf, 4'b0000);
    req = 4'b0010;
    for (int i = 0; i < LAT - 1; i++) tick("coll_wait");
    ack = 1'b1; ack_idx = 2'd1; tick("coll"); ack = 1'b0; req = 4'b0000;
    check_eq("coll_pend", pending, 4'b0010);
    check_eq("coll_ovf", ovf, 4'b0000);
    tick("coll_idle");

    // asynchronous reset mid-cycle with 1010 pending
    ack = 1'b1; ack_idx = 2'd1; tick("pre_rst"); ack = 1'b0;
    pulse(4'b1010, "pre_rst");
    check_eq("pre_rst_pend", pending, 4'b1010);
    pulse(4'b1000, "pre_rst_ovf");
    @(posedge clk); model_step();
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_eq("arst_pend", pending, 4'b0000);
    check_eq("arst_ovf", ovf, 4'b0000);
    check_eq("arst_irq", {3'b000, irq}, 4'b0000);
    check_eq("arst_I", I, 4'b0000);
    // req held high through release must be seen as a rising edge
    req = 4'b0001;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < LAT + 1; i++) tick("rel");
    check_eq("rel_pend", pending, 4'b0001);

    // randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      req     = 4'($urandom);
      ack     = ($urandom_range(1, 0) == 1);
      ack_idx = ($urandom_range(9, 0) < 7) ? enc(m_pend & ~m_mask) : 2'($urandom);
      mask_we = ($urandom_range(9, 0) == 0);
      mask_d  = 4'($urandom);
      ovf_clr = ($urandom_range(9, 0) == 0);
      tick("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
